// File: rtl/eth_tx_framer.sv
// Byte-wide Ethernet transmit framer: preamble, SFD, payload, zero padding, CRC-32 FCS
// and a forced inter-frame gap, with a one-cycle txer pulse when the source underruns.
module eth_tx_framer #(
  parameter int PREAMBLE_BYTES  = 7,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int APPEND_FCS      = 1,
  parameter int IFG_BYTES       = 12
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_txen,
  input  logic [7:0] in_txd,
  input  logic       in_txlast,
  output logic       out_tx_ready,
  output logic       out_wire_txen,
  output logic [7:0] out_wire_txd,
  output logic       out_wire_txer,
  output logic       out_busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_PAD  = 3'd4;
  localparam logic [2:0] S_FCS  = 3'd5;
  localparam logic [2:0] S_IFG  = 3'd6;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] MIN_LEN  = 32'(MIN_FRAME_BYTES);
  localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_BYTES);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]  ifg_cnt_q, ifg_cnt_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [15:0] count_q, count_d;
  logic [31:0] crc_q, crc_d;
  logic        ready_q, ready_d;
  logic        txen_q, txen_d;
  logic [7:0]  txd_q, txd_d;
  logic        txer_q, txer_d;
  logic        busy_q, busy_d;

  logic [15:0] count_inc;
  logic        pad_more;
  logic [2:0]  tail_state;
  logic [31:0] fcs;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Where a frame goes after the byte being emitted now: more padding, FCS, or straight to the gap.
  always_comb begin
    count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    pad_more  = ({16'd0, count_inc} < MIN_LEN);
    if (pad_more) begin
      tail_state = S_PAD;
    end else if (APPEND_FCS != 0) begin
      tail_state = S_FCS;
    end else begin
      tail_state = S_IFG;
    end
    fcs = ~crc_q;
  end

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = 4'd0;
    ifg_cnt_d = 8'd0;
    fcs_idx_d = 2'd0;
    count_d   = count_q;
    crc_d     = crc_q;
    ready_d   = 1'b0;
    txen_d    = 1'b0;
    txd_d     = 8'h00;
    txer_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_txen) begin
          state_d   = S_PRE;
          pre_cnt_d = 4'd1;
          crc_d     = CRC_INIT;
          count_d   = 16'd0;
          txen_d    = 1'b1;
          txd_d     = 8'h55;
        end
      end
      S_PRE: begin
        txen_d = 1'b1;
        if (pre_cnt_q == PRE_LAST) begin
          state_d = S_SFD;
          txd_d   = 8'hD5;
          ready_d = 1'b1;
        end else begin
          pre_cnt_d = pre_cnt_q + 4'd1;
          txd_d     = 8'h55;
        end
      end
      // Ready is already high in SFD, so a missing byte there is an underrun just like in DATA.
      S_SFD, S_DATA: begin
        txen_d = 1'b1;
        if (in_txen) begin
          txd_d   = in_txd;
          crc_d   = crc_byte(crc_q, in_txd);
          count_d = count_inc;
          if (in_txlast) begin
            state_d = tail_state;
          end else begin
            state_d = S_DATA;
            ready_d = 1'b1;
          end
        end else begin
          txer_d  = 1'b1;
          state_d = S_IFG;
        end
      end
      S_PAD: begin
        txen_d  = 1'b1;
        crc_d   = crc_byte(crc_q, 8'h00);
        count_d = count_inc;
        state_d = tail_state;
      end
      S_FCS: begin
        txen_d    = 1'b1;
        txd_d     = fcs[{fcs_idx_q, 3'b000} +: 8];
        fcs_idx_d = fcs_idx_q + 2'd1;
        if (fcs_idx_q == 2'd3) begin
          state_d = S_IFG;
        end
      end
      S_IFG: begin
        ifg_cnt_d = ifg_cnt_q + 8'd1;
        if (ifg_cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= 4'd0;
      ifg_cnt_q <= 8'd0;
      fcs_idx_q <= 2'd0;
      count_q   <= 16'd0;
      crc_q     <= CRC_INIT;
      ready_q   <= 1'b0;
      txen_q    <= 1'b0;
      txd_q     <= 8'h00;
      txer_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      ifg_cnt_q <= ifg_cnt_d;
      fcs_idx_q <= fcs_idx_d;
      count_q   <= count_d;
      crc_q     <= crc_d;
      ready_q   <= ready_d;
      txen_q    <= txen_d;
      txd_q     <= txd_d;
      txer_q    <= txer_d;
      busy_q    <= busy_d;
    end
  end

  assign out_tx_ready  = ready_q;
  assign out_wire_txen = txen_q;
  assign out_wire_txd  = txd_q;
  assign out_wire_txer = txer_q;
  assign out_busy      = busy_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: three instances with different parameters, a per-cycle
// wire trace for each, and expected frames built from an independent bit-serial CRC model.
module tb_eth_tx_framer;

  typedef struct packed {
    logic       txen;
    logic       txer;
    logic       ready;
    logic       busy;
    logic [7:0] txd;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txen_a [3];
  logic       last_a [3];
  logic [7:0] txd_a  [3];
  logic       rdy_w  [3];
  logic       wtxen_w[3];
  logic       wtxer_w[3];
  logic       busy_w [3];
  logic [7:0] wtxd_w [3];

  cyc_t       tr[3][$];
  logic [7:0] pl[$], ex[$], rb[$], pa[$], pb[$];
  int r_len, r_txer, r_txer_pos, r_gap, r_busy_after, r_ready, r_busy_in;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  eth_tx_framer u_def (
    .clock(clk), .reset_n(rst_n), .in_txen(txen_a[0]), .in_txd(txd_a[0]), .in_txlast(last_a[0]),
    .out_tx_ready(rdy_w[0]), .out_wire_txen(wtxen_w[0]), .out_wire_txd(wtxd_w[0]),
    .out_wire_txer(wtxer_w[0]), .out_busy(busy_w[0])
  );

  eth_tx_framer #(.MIN_FRAME_BYTES(0)) u_nopad (
    .clock(clk), .reset_n(rst_n), .in_txen(txen_a[1]), .in_txd(txd_a[1]), .in_txlast(last_a[1]),
    .out_tx_ready(rdy_w[1]), .out_wire_txen(wtxen_w[1]), .out_wire_txd(wtxd_w[1]),
    .out_wire_txer(wtxer_w[1]), .out_busy(busy_w[1])
  );

  eth_tx_framer #(.PREAMBLE_BYTES(3), .MIN_FRAME_BYTES(8), .APPEND_FCS(0), .IFG_BYTES(4)) u_small (
    .clock(clk), .reset_n(rst_n), .in_txen(txen_a[2]), .in_txd(txd_a[2]), .in_txlast(last_a[2]),
    .out_tx_ready(rdy_w[2]), .out_wire_txen(wtxen_w[2]), .out_wire_txd(wtxd_w[2]),
    .out_wire_txer(wtxer_w[2]), .out_busy(busy_w[2])
  );

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      tr[k].push_back({wtxen_w[k], wtxer_w[k], rdy_w[k], busy_w[k], wtxd_w[k]});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("check %s got=0x%08h ok", tag, got);
    end
  endtask

  // Reference CRC fed one bit at a time, LSB first.
  function automatic logic [31:0] ref_crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic build_exp(input int pre, input int minb, input bit with_fcs);
    logic [31:0] crc;
    logic [31:0] f;
    int          n;
    ex.delete();
    for (int i = 0; i < pre; i++) ex.push_back(8'h55);
    ex.push_back(8'hD5);
    crc = 32'hFFFFFFFF;
    n   = 0;
    for (int i = 0; i < pl.size(); i++) begin
      ex.push_back(pl[i]);
      crc = ref_crc8(crc, pl[i]);
      n++;
    end
    while (n < minb) begin
      ex.push_back(8'h00);
      crc = ref_crc8(crc, 8'h00);
      n++;
    end
    if (with_fcs) begin
      f = ~crc;
      for (int i = 0; i < 4; i++) ex.push_back(f[8*i +: 8]);
    end
  endtask

  function automatic int nbad();
    int n;
    n = (rb.size() != ex.size()) ? 1000 : 0;
    for (int i = 0; i < rb.size() && i < ex.size(); i++) begin
      if (rb[i] !== ex[i]) n++;
    end
    return n;
  endfunction

  // Extract the r-th txen-high run of instance k plus what follows it.
  task automatic get_run(input int k, input int r);
    int i, s, j, run, n;
    rb.delete();
    r_len = 0; r_txer = 0; r_txer_pos = -1; r_gap = 0; r_busy_after = 0; r_ready = 0; r_busy_in = 0;
    n = tr[k].size();
    i = 0;
    run = 0;
    while (i < n) begin
      if (tr[k][i].txen !== 1'b1) begin
        i++;
      end else begin
        s = i;
        while (i < n && tr[k][i].txen === 1'b1) i++;
        if (run == r) begin
          for (int m = s; m < i; m++) begin
            rb.push_back(tr[k][m].txd);
            if (tr[k][m].txer === 1'b1) begin r_txer++; r_txer_pos = m - s; end
            if (tr[k][m].ready === 1'b1) r_ready++;
            if (tr[k][m].busy === 1'b1) r_busy_in++;
          end
          r_len = i - s;
          j = i;
          while (j < n && tr[k][j].txen !== 1'b1) j++;
          r_gap = j - i;
          j = i;
          while (j < n && tr[k][j].txen !== 1'b1 && tr[k][j].busy === 1'b1) j++;
          r_busy_after = j - i;
          i = n;
        end
        run++;
      end
    end
  endtask

  // Request a frame, then hand over pl[] as ready allows; abort_at >= 0 drops txen before that byte.
  task automatic send(input int k, input int abort_at, input bit hold);
    int idx, cyc;
    bit done;
    idx = 0; cyc = 0; done = 0;
    txen_a[k] = 1'b1;
    txd_a[k]  = 8'hAA;
    last_a[k] = 1'b0;
    while (!done && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rdy_w[k] === 1'b1 && idx == abort_at) begin
        txen_a[k] = 1'b0;
        last_a[k] = 1'b0;
        done = 1;
      end else if (rdy_w[k] === 1'b1 && idx < pl.size()) begin
        txd_a[k]  = pl[idx];
        last_a[k] = (idx == pl.size() - 1);
        idx++;
      end else if (rdy_w[k] !== 1'b1 && idx == pl.size()) begin
        if (!hold) txen_a[k] = 1'b0;
        last_a[k] = 1'b0;
        done = 1;
      end
    end
    check("send_done", 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input int k, input string tag);
    int c;
    c = 0;
    while (busy_w[k] !== 1'b0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(busy_w[k]), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      txen_a[k] = 1'b0;
      txd_a[k]  = 8'h00;
      last_a[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_outs_%0d", k), 32'({busy_w[k], rdy_w[k], wtxer_w[k], wtxen_w[k], wtxd_w[k]}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 20-byte payload, padded to 60, FCS appended
    tr[0].delete();
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'(i));
    send(0, -1, 0);
    wait_idle(0, "t1_idle");
    build_exp(7, 60, 1);
    get_run(0, 0);
    check("t1_len", r_len, 72);
    check("t1_bytes_bad", nbad(), 0);
    check("t1_txer", r_txer, 0);
    check("t1_ready_cycles", r_ready, 20);
    check("t1_busy_in_run", r_busy_in, 72);
    // the last gap cycle is the IDLE cycle that samples the next request, so busy is low there
    check("t1_busy_after", r_busy_after, 11);

    // no padding, known CRC of "123456789"
    tr[1].delete();
    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send(1, -1, 0);
    wait_idle(1, "t2_idle");
    build_exp(7, 0, 1);
    get_run(1, 0);
    check("t2_len", r_len, 21);
    check("t2_bytes_bad", nbad(), 0);
    check("t2_fcs", (r_len == 21) ? {rb[20], rb[19], rb[18], rb[17]} : 32'd0, 32'hCBF43926);

    // underrun after 5 bytes
    tr[0].delete();
    pl = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    send(0, 5, 0);
    wait_idle(0, "t3_idle");
    pl = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    build_exp(7, 0, 0);
    ex.push_back(8'h00);
    get_run(0, 0);
    check("t3_len", r_len, 14);
    check("t3_bytes_bad", nbad(), 0);
    check("t3_txer_count", r_txer, 1);
    check("t3_txer_pos", r_txer_pos, 13);
    check("t3_ready_cycles", r_ready, 6);
    check("t3_busy_in_run", r_busy_in, 14);
    check("t3_busy_after", r_busy_after, 11);

    // two back-to-back 64-byte frames with the request held high
    tr[0].delete();
    pa.delete();
    pb.delete();
    for (int i = 0; i < 64; i++) begin
      pa.push_back(8'(i * 3 + 7));
      pb.push_back(8'($urandom_range(0, 255)));
    end
    pl = pa;
    send(0, -1, 1);
    pl = pb;
    send(0, -1, 0);
    wait_idle(0, "t4_idle");
    pl = pa;
    build_exp(7, 60, 1);
    get_run(0, 0);
    check("t4a_len", r_len, 76);
    check("t4a_bytes_bad", nbad(), 0);
    check("t4_gap", r_gap, 12);
    pl = pb;
    build_exp(7, 60, 1);
    get_run(0, 1);
    check("t4b_len", r_len, 76);
    check("t4b_bytes_bad", nbad(), 0);

    // short preamble, no FCS, 4-cycle gap; second frame padded to 8
    tr[2].delete();
    pa.delete();
    pb.delete();
    for (int i = 0; i < 10; i++) pa.push_back(8'(8'h10 + i));
    for (int i = 0; i < 5; i++) pb.push_back(8'(8'hE0 + i));
    pl = pa;
    send(2, -1, 1);
    pl = pb;
    send(2, -1, 0);
    wait_idle(2, "t5_idle");
    pl = pa;
    build_exp(3, 8, 0);
    get_run(2, 0);
    check("t5a_len", r_len, 14);
    check("t5a_bytes_bad", nbad(), 0);
    check("t5_gap", r_gap, 4);
    pl = pb;
    build_exp(3, 8, 0);
    get_run(2, 1);
    check("t5b_len", r_len, 12);
    check("t5b_bytes_bad", nbad(), 0);
    check("t5b_busy_after", r_busy_after, 3);

    // asynchronous reset in the middle of padding, then a clean frame
    pl = '{8'h01, 8'h02, 8'h03};
    send(0, -1, 0);
    @(posedge clk);
    #3;
    check("t6_in_pad", 32'({wtxen_w[0], wtxd_w[0]}), 32'h100);
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", 32'({busy_w[0], rdy_w[0], wtxer_w[0], wtxen_w[0], wtxd_w[0]}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tr[0].delete();
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'(i));
    send(0, -1, 0);
    wait_idle(0, "t6_idle");
    build_exp(7, 60, 1);
    get_run(0, 0);
    check("t6_len", r_len, 72);
    check("t6_bytes_bad", nbad(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
